// File: rtl/irq_mask_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : irq_mask_ctrl_pkg
//  Purpose  : Shared constants for the IRQ mask controller: line count,
//             register offsets, MODE encodings, bus FSM states and the
//             interrupt-ID to line decoder.
//  Ports    : none (package)
//  Revision : 1.0  initial release
// ============================================================================
package irq_mask_ctrl_pkg;

  // The downstream priority encoder handles exactly 8 lines.
  localparam int NUM_IRQ = 8;

  // Register map (bus_addr)
  localparam logic [2:0] REG_ENABLE  = 3'd0;
  localparam logic [2:0] REG_MODE    = 3'd1;
  localparam logic [2:0] REG_PENDING = 3'd2;
  localparam logic [2:0] REG_FORCE   = 3'd3;
  localparam logic [2:0] REG_STATUS  = 3'd4;
  localparam logic [2:0] REG_LOG     = 3'd5;

  // MODE bit encodings
  localparam logic MODE_EDGE  = 1'b0;
  localparam logic MODE_LEVEL = 1'b1;

  // Bus FSM states
  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RESP = 1'b1;

  // Interrupt IDs are 1-based. IDs outside 1..NUM_IRQ decode to all-zero,
  // so an out-of-range delivery touches nothing.
  function automatic logic [NUM_IRQ-1:0] id_to_onehot(input logic [7:0] id);
    logic [NUM_IRQ-1:0] oh;
    oh = '0;
    for (int i = 0; i < NUM_IRQ; i++) begin
      oh[i] = (id == 8'(i + 1));
    end
    return oh;
  endfunction

endpackage
`default_nettype wire

// File: rtl/irq_mask_ctrl_sync.sv
`default_nettype none
// ============================================================================
//  Module   : irq_sync
//  Purpose  : Parameterised 2-flop synchroniser for asynchronous IRQ lines.
//  Ports    : clk   in  1      system clock
//             reset in  1      asynchronous, active-high reset
//             d     in  WIDTH  asynchronous inputs
//             q     out WIDTH  synchronised outputs (2-cycle latency)
//  Revision : 1.0  initial release
// ============================================================================
module irq_sync #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  (* ASYNC_REG = "TRUE" *) logic [WIDTH-1:0] meta;
  (* ASYNC_REG = "TRUE" *) logic [WIDTH-1:0] sync_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta   <= '0;
      sync_q <= '0;
    end else begin
      meta   <= d;
      sync_q <= meta;
    end
  end

  assign q = sync_q;

endmodule
`default_nettype wire

// File: rtl/irq_mask_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : irq_mask_ctrl
//  Purpose  : MMIO front end for 8 interrupt lines: per-line enable,
//             edge/level mode, sticky pending, software force, delivery
//             auto-clear and a delivery log.
//  Ports    : clk          in  1        system clock
//             reset        in  1        asynchronous, active-high reset
//             irq_in       in  NUM_IRQ  raw peripheral IRQ lines (async)
//             int_cpu      in  1        delivery strobe from the controller
//             int_id       in  8        delivered interrupt ID (1..8)
//             bus_start    in  1        1-cycle access strobe
//             bus_we       in  1        1=write, 0=read
//             bus_addr     in  3        register index
//             bus_data_in  in  32       write data
//             bus_data_out out 32       read data, valid with bus_done
//             bus_done     out 1        access complete pulse
//             irq_out      out NUM_IRQ  gated lines to the controller
//  Revision : 1.0  initial release
// ============================================================================
module irq_mask_ctrl
  import irq_mask_ctrl_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_IRQ-1:0] irq_in,
  input  logic               int_cpu,
  input  logic [7:0]         int_id,
  input  logic               bus_start,
  input  logic               bus_we,
  input  logic [2:0]         bus_addr,
  input  logic [31:0]        bus_data_in,
  output logic [31:0]        bus_data_out,
  output logic               bus_done,
  output logic [NUM_IRQ-1:0] irq_out
);

  logic [NUM_IRQ-1:0] sync;
  logic [NUM_IRQ-1:0] sync_prev;
  logic [NUM_IRQ-1:0] sync_edge;
  logic [NUM_IRQ-1:0] src_set;

  logic [NUM_IRQ-1:0] enable;
  logic [NUM_IRQ-1:0] mode;
  logic [NUM_IRQ-1:0] pending;
  logic [NUM_IRQ-1:0] pend_next;

  logic               int_cpu_prev;
  logic [NUM_IRQ-1:0] deliv_hit;
  logic               deliv_valid;
  logic [7:0]         last_id;
  logic [23:0]        deliv_cnt;

  logic [0:0]         state;
  logic               wr;
  logic               rd;
  logic [NUM_IRQ-1:0] wdata;
  logic [NUM_IRQ-1:0] force_set;
  logic [NUM_IRQ-1:0] w1c_clr;
  logic [31:0]        rd_data;

  // Upper write-data bits have no register behind them.
  logic               unused_wdata;
  assign unused_wdata = ^bus_data_in[31:NUM_IRQ];

  // --------------------------------------------------------------------------
  // Input synchronisation and source detection
  // --------------------------------------------------------------------------
  irq_sync #(
    .WIDTH (NUM_IRQ)
  ) u_irq_sync (
    .clk   (clk),
    .reset (reset),
    .d     (irq_in),
    .q     (sync)
  );

  assign sync_edge = sync & ~sync_prev;

  generate
    for (genvar i = 0; i < NUM_IRQ; i++) begin : g_src
      assign src_set[i] = (mode[i] == MODE_LEVEL) ? sync[i] : sync_edge[i];
    end
  endgenerate

  // --------------------------------------------------------------------------
  // Bus decode: writes act on the bus_start edge itself
  // --------------------------------------------------------------------------
  assign wr        = bus_start & bus_we;
  assign rd        = bus_start & ~bus_we;
  assign wdata     = bus_data_in[NUM_IRQ-1:0];
  assign force_set = (wr && bus_addr == REG_FORCE)   ? wdata : '0;
  assign w1c_clr   = (wr && bus_addr == REG_PENDING) ? wdata : '0;

  // --------------------------------------------------------------------------
  // Delivery detection: rising edge of int_cpu with a valid ID
  // --------------------------------------------------------------------------
  assign deliv_hit   = (int_cpu & ~int_cpu_prev) ? id_to_onehot(int_id) : '0;
  assign deliv_valid = |deliv_hit;

  // Sets win over clears so a source event coinciding with a W1C or a
  // delivery is never dropped.
  assign pend_next = (pending & ~(w1c_clr | deliv_hit)) | src_set | force_set;

  // --------------------------------------------------------------------------
  // Read mux (sampled at the access edge, i.e. pre-write values)
  // --------------------------------------------------------------------------
  always_comb begin
    rd_data = '0;
    case (bus_addr)
      REG_ENABLE:  rd_data = 32'(enable);
      REG_MODE:    rd_data = 32'(mode);
      REG_PENDING: rd_data = 32'(pending);
      REG_FORCE:   rd_data = '0;
      REG_STATUS:  rd_data = 32'(sync);
      REG_LOG:     rd_data = {deliv_cnt, last_id};
      default:     rd_data = '0;
    endcase
  end

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_prev    <= '0;
      enable       <= '0;
      mode         <= '0;
      pending      <= '0;
      int_cpu_prev <= 1'b0;
      last_id      <= '0;
      deliv_cnt    <= '0;
      state        <= ST_IDLE;
      bus_data_out <= '0;
      irq_out      <= '0;
    end else begin
      sync_prev    <= sync;
      int_cpu_prev <= int_cpu;
      pending      <= pend_next;

      // A delivered line is held low for this cycle so a re-set pending bit
      // shows up at the controller as a fresh rising edge.
      irq_out      <= pend_next & enable & ~deliv_hit;

      if (deliv_valid) begin
        last_id   <= int_id;
        deliv_cnt <= deliv_cnt + 24'd1;
      end

      if (wr && bus_addr == REG_ENABLE) begin
        enable <= wdata;
      end
      if (wr && bus_addr == REG_MODE) begin
        mode <= wdata;
      end

      // Read data holds across writes and idle cycles until the next read.
      if (rd) begin
        bus_data_out <= rd_data;
      end

      // A new access in RESP keeps us in RESP: one access per cycle.
      state <= bus_start ? ST_RESP : ST_IDLE;
    end
  end

  assign bus_done = (state == ST_RESP);

endmodule
`default_nettype wire
